// File: rtl/rms_fifo_pkg.sv
// rms_fifo_pkg: shared FIFO sizing constants and pointer-width helper.
package rms_fifo_pkg;
    localparam int RMS_WIDTH = 32;
    localparam int RMS_DEPTH = 32;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/rms_fifo_mem.sv
// rms_fifo_mem: simple dual-port array with registered read port, read-before-write on collision.
module rms_fifo_mem import rms_fifo_pkg::*; #(
    parameter int WIDTH = RMS_WIDTH,
    parameter int DEPTH = RMS_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= r_mem[raddr];
    end
endmodule

// File: rtl/rms_fifo.sv
// rms_fifo: parametrised synchronous FIFO with count, almost-full and read-valid strobe.
// Define RMS_FIFO_ERR_EN to add sticky overflow/underflow flags.
module rms_fifo import rms_fifo_pkg::*; #(
    parameter int WIDTH     = RMS_WIDTH,
    parameter int DEPTH     = RMS_DEPTH,
    parameter int AF_MARGIN = 4,
    localparam int PW = ptr_w(DEPTH),
    localparam int AW = PW - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pushin,
    input  logic [WIDTH-1:0] datain,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dataout,
    output logic             dout_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
`ifdef RMS_FIFO_ERR_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [PW-1:0]    count
);
    logic [PW-1:0] r_wptr, r_rptr, w_count_nxt;
    logic          w_rd_ok, w_wr_ok;
    assign w_rd_ok     = rd_en && !empty;
    assign w_wr_ok     = pushin && (!full || w_rd_ok);
    assign w_count_nxt = count + PW'(w_wr_ok) - PW'(w_rd_ok);

    rms_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_ok),
        .waddr (r_wptr[AW-1:0]),
        .wdata (datain),
        .re    (w_rd_ok),
        .raddr (r_rptr[AW-1:0]),
        .rdata (dataout)
    );

    // Flags come from the next-state count so they are exact right after each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            dout_valid  <= 1'b0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
            count       <= w_count_nxt;
            empty       <= w_count_nxt == '0;
            full        <= w_count_nxt == PW'(DEPTH);
            almost_full <= w_count_nxt >= PW'(DEPTH - AF_MARGIN);
            dout_valid  <= w_rd_ok;
        end
    end

`ifdef RMS_FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow | (pushin && full && !w_rd_ok);
            underflow <= underflow | (rd_en && empty);
        end
    end
`endif
endmodule

// File: tb/tb_rms_fifo.sv
// tb_rms_fifo: directed self-checking bench for rms_fifo at default 32x32 with AF_MARGIN 4.
module tb_rms_fifo;
    logic        clk = 0, rst = 1, pushin = 0, rd_en = 0;
    logic [31:0] datain = 0, dataout;
    logic        dout_valid, empty, full, almost_full;
    logic [5:0]  count;
`ifdef RMS_FIFO_ERR_EN
    logic        overflow, underflow;
`endif
    int checks = 0, errors = 0;

    rms_fifo dut (
        .clk(clk), .rst(rst), .pushin(pushin), .datain(datain), .rd_en(rd_en),
        .dataout(dataout), .dout_valid(dout_valid), .empty(empty), .full(full),
        .almost_full(almost_full),
`ifdef RMS_FIFO_ERR_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL reset_dataout got %h exp 0", dataout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
`ifdef RMS_FIFO_ERR_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b exp 0", underflow); end
`endif
        rst = 0;
    endtask

    task automatic test_order();
        for (int i = 0; i < 4; i++) begin
            pushin = 1; datain = 32'hA0 + i;
            tick();
            checks++; if (count !== 6'(i + 1)) begin errors++; $display("FAIL order_push_count got %0d exp %0d", count, i + 1); end
        end
        pushin = 0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", empty); end
        for (int i = 0; i < 4; i++) begin
            rd_en = 1;
            tick();
            checks++; if (dataout !== 32'hA0 + i) begin errors++; $display("FAIL order_data got %h exp %h", dataout, 32'hA0 + i); end
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL order_valid got %b exp 1", dout_valid); end
            checks++; if (count !== 6'(3 - i)) begin errors++; $display("FAIL order_count got %0d exp %0d", count, 3 - i); end
        end
        rd_en = 0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty_end got %b exp 1", empty); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL order_valid_end got %b exp 0", dout_valid); end
        checks++; if (dataout !== 32'hA3) begin errors++; $display("FAIL order_hold got %h exp a3", dataout); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            pushin = 1; datain = 32'h100 + i;
            tick();
            checks++; if (count !== 6'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 28)) begin errors++; $display("FAIL fill_af got %b at count %0d", almost_full, i + 1); end
            checks++; if (full !== (i + 1 == 32)) begin errors++; $display("FAIL fill_full got %b at count %0d", full, i + 1); end
        end
        datain = 32'h999;
        tick();
        pushin = 0;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL ovf_count got %0d exp 32", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", full); end
`ifdef RMS_FIFO_ERR_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
`endif
        rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (dataout !== 32'h100) begin errors++; $display("FAIL ovf_first got %h exp 100", dataout); end
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL ovf_count_rd got %0d exp 31", count); end
        pushin = 1; datain = 32'h120;
        tick();
        pushin = 0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL refill_full got %b exp 1", full); end
    endtask

    task automatic test_full_simul();
        pushin = 1; rd_en = 1; datain = 32'hFF;
        tick();
        pushin = 0;
        checks++; if (dataout !== 32'h101) begin errors++; $display("FAIL fsim_data got %h exp 101", dataout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL fsim_valid got %b exp 1", dout_valid); end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL fsim_count got %0d exp 32", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fsim_full got %b exp 1", full); end
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++; if (dataout !== ((i < 31) ? 32'h102 + i : 32'hFF)) begin errors++; $display("FAIL fsim_drain got %h at read %0d", dataout, i); end
        end
        rd_en = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fsim_empty got %b exp 1", empty); end
    endtask

    task automatic test_empty_simul();
        pushin = 1; rd_en = 1; datain = 32'h55;
        tick();
        pushin = 0;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL esim_valid got %b exp 0", dout_valid); end
        checks++; if (dataout !== 32'hFF) begin errors++; $display("FAIL esim_hold got %h exp ff", dataout); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL esim_count got %0d exp 1", count); end
`ifdef RMS_FIFO_ERR_EN
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL esim_unf got %b exp 1", underflow); end
`endif
        tick();
        rd_en = 0;
        checks++; if (dataout !== 32'h55) begin errors++; $display("FAIL esim_data got %h exp 55", dataout); end
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL esim_valid2 got %b exp 1", dout_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_d;
        logic        p, r, rd_ok, wr_ok;
        for (int i = 0; i < 300; i++) begin
            p = 1'($urandom % 2); r = 1'($urandom % 2);
            pushin = p; rd_en = r; datain = $urandom;
            rd_ok = r && q.size() != 0;
            wr_ok = p && (q.size() < 32 || rd_ok);
            exp_d = rd_ok ? q.pop_front() : 32'h0;
            if (wr_ok) q.push_back(datain);
            tick();
            checks++; if (count !== 6'(q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d cycle %0d", count, q.size(), i); end
            checks++; if (dout_valid !== rd_ok) begin errors++; $display("FAIL rnd_valid got %b exp %b cycle %0d", dout_valid, rd_ok, i); end
            if (rd_ok) begin
                checks++; if (dataout !== exp_d) begin errors++; $display("FAIL rnd_data got %h exp %h cycle %0d", dataout, exp_d, i); end
            end
        end
        pushin = 0; rd_en = 1;
        while (q.size() != 0) begin
            exp_d = q.pop_front();
            tick();
            checks++; if (dataout !== exp_d) begin errors++; $display("FAIL rnd_drain got %h exp %h", dataout, exp_d); end
        end
        rd_en = 0;
        tick();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rnd_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 11; i++) begin
            pushin = 1; datain = 32'h200 + i;
            tick();
        end
        pushin = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (count !== 6'd10) begin errors++; $display("FAIL rmid_pre got %0d exp 10", count); end
        checks++; if (dataout !== 32'h200) begin errors++; $display("FAIL rmid_pre_data got %h exp 200", dataout); end
        #2 rst = 1;
        #1;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", empty); end
        checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", dataout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", dout_valid); end
        tick();
        rst = 0;
        pushin = 1; datain = 32'h77;
        tick();
        pushin = 0; rd_en = 1;
        tick();
        rd_en = 0;
        checks++; if (dataout !== 32'h77) begin errors++; $display("FAIL rmid_new got %h exp 77", dataout); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty2 got %b exp 1", empty); end
        tick();
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid2 got %b exp 0", dout_valid); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_fill();
        test_full_simul();
        test_empty_simul();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
